// File: rtl/r16_input_gather.sv
// -----------------------------------------------------------------------------
// r16_input_gather
//   Serial-to-parallel frame gatherer for the radix-16 input path. Words arrive
//   one per cycle and are packed, in arrival order, into a LANES-wide vector.
//   Two banks work as a ping-pong pair: one fills while the other waits for
//   downstream, so input streaming continues while a vector is pending.
//
// Ports
//   clk        in   single clock, posedge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous clear (drops partial frame and pending vectors)
//   in_valid   in   input word valid
//   in_data    in   input word (D_WIDTH)
//   in_ready   out  block can take in_data this cycle
//   out_valid  out  out_data holds a complete vector
//   out_ready  in   downstream takes the vector this cycle
//   out_data   out  LANES*D_WIDTH, lane i at [i*D_WIDTH +: D_WIDTH]
//   lane_cnt   out  words already written into the current fill bank
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. in_ready depends only on registers. Once out_valid is raised, out_valid
// and out_data stay put until the vector is taken (or clr/rst discards it).
// -----------------------------------------------------------------------------
module r16_input_gather #(
  parameter int D_WIDTH = 64,
  parameter int LANES   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [D_WIDTH-1:0]         in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*D_WIDTH-1:0]   out_data,
  output logic [$clog2(LANES)-1:0]   lane_cnt
);

  localparam int CW = $clog2(LANES);

  logic [LANES-1:0][D_WIDTH-1:0] bank_q [2];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] lane_cnt_q, lane_cnt_d;

  logic accept;
  logic pop;
  logic last_word;

  // The fill bank is never the one waiting downstream unless both are full,
  // so ready only has to look at the fill bank's flag.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_data  = bank_q[rd_bank_q];
  assign lane_cnt  = lane_cnt_q;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign last_word = (lane_cnt_q == CW'(LANES - 1));

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    lane_cnt_d = lane_cnt_q;
    if (clr) begin
      full_d     = '0;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      lane_cnt_d = '0;
    end else begin
      if (accept) begin
        // Natural wrap of the counter closes the frame.
        lane_cnt_d = lane_cnt_q + CW'(1);
        if (last_word) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
      // A pop always targets the other bank than a completing fill (the fill
      // bank is empty, the read bank is full), so both updates can coexist.
      if (pop) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      lane_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Bank storage: clr leaves contents alone (they are unreachable until
  // overwritten) and blocks a concurrent write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '{default: '0};
    end else if (accept && !clr) begin
      bank_q[wr_bank_q][lane_cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_r16_input_gather.sv
module tb_r16_input_gather;

  localparam int DW    = 64;
  localparam int LANES = 16;
  localparam int VW    = DW * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic [3:0]    lane_cnt;

  r16_input_gather #(.D_WIDTH(DW), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lane_cnt  (lane_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Completed vectors not yet taken downstream, oldest first, and words of the
  // frame currently being gathered. The block is a 2-deep vector FIFO.
  logic [VW-1:0] exp_q[$];
  logic [DW-1:0] part_q[$];

  // Inputs presented for the upcoming edge, and whether the model expects them
  // to be taken on that edge.
  logic          pend_v   = 1'b0;
  logic          pend_c   = 1'b0;
  logic          pend_rdy = 1'b0;
  logic [DW-1:0] pend_d   = '0;
  logic          mon_en   = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_commit();
    logic [VW-1:0] vec;
    if (pend_c) begin
      exp_q.delete();
      part_q.delete();
    end else if (pend_v && pend_rdy) begin
      part_q.push_back(pend_d);
      if (part_q.size() == LANES) begin
        vec = '0;
        for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = part_q[i];
        exp_q.push_back(vec);
        part_q.delete();
      end
    end
    pend_v = 1'b0;
    pend_c = 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic c);
    @(posedge clk);
    #1;
    model_commit();
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    pend_v    = v;
    pend_d    = d;
    pend_c    = c;
    pend_rdy  = (exp_q.size() < 2);
  endtask

  // Push words lo..hi in order, retrying each until taken.
  task automatic push_words(input int lo, input int hi, input logic ordy);
    int w = lo;
    int guard = 0;
    while (w <= hi && guard < 400) begin
      step(1'b1, DW'(w), ordy, 1'b0);
      if (pend_rdy) w++;
      guard++;
    end
    check("push_progress", 64'(w), 64'(hi + 1));
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || pend_v) && guard < 20) begin
      step(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_lane_cnt"},  64'(lane_cnt),  64'd0);
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL %s_out_data actual=nonzero required=0", tag);
    end
  endtask

  // Async reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #3;
    mon_en   = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    part_q.delete();
    pend_v = 1'b0;
    pend_c = 1'b0;
    @(negedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("lane_cnt",  64'(lane_cnt),  64'(part_q.size()));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        logic [VW-1:0] exp_v;
        exp_v = exp_q.pop_front();
        checks++;
        if (out_data !== exp_v) begin
          errors++;
          for (int i = 0; i < LANES; i++) begin
            if (out_data[i*DW +: DW] !== exp_v[i*DW +: DW]) begin
              $display("FAIL out_data lane %0d actual=%0h expected=%0h at %0t",
                       i, out_data[i*DW +: DW], exp_v[i*DW +: DW], $time);
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int accepted;
    int stall;

    // Reset
    reset_pulse("reset");

    // Single frame, back-to-back, downstream always ready
    push_words(0, 15, 1'b1);
    drain();

    // Simultaneous pop of bank0 with completion of bank1
    push_words(0, 15, 1'b0);
    push_words(16, 30, 1'b0);
    push_words(31, 31, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Backpressure: 48 words, downstream stalled until input blocks a while
    stall = 0;
    begin
      int w = 0;
      int guard = 0;
      while (w < 48 && guard < 400) begin
        step(1'b1, DW'(w), (stall >= 5), 1'b0);
        if (pend_rdy) w++;
        else stall++;
        guard++;
      end
      check("bp_words", 64'(w), 64'd48);
    end
    check("bp_stalled", 64'(stall >= 5), 64'd1);
    drain();

    // Random gaps on both sides, 10 frames
    accepted = 0;
    for (int cyc = 0; cyc < 2000 && accepted < 10 * LANES; cyc++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      if (pend_v && pend_rdy) accepted++;
    end
    check("rand_words", 64'(accepted), 64'(10 * LANES));
    drain();

    // Clear with a pending vector and a 7-word partial frame
    push_words(0, 15, 1'b0);
    push_words(32, 38, 1'b0);
    step(1'b1, 64'hDEAD, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    push_words(32'h100, 32'h10F, 1'b1);
    drain();

    // Reset mid-frame discards partial and pending data
    push_words(0, 15, 1'b0);
    push_words(64, 68, 1'b0);
    reset_pulse("midreset");
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    push_words(32'h200, 32'h20F, 1'b1);
    drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
